code_compare_sequencer: RTL
===========================

Name: code_compare_sequencer

Overview:
- Sequences one shared 4-bit two's-complement subtractor (A − B = A + ~B + 1) to compare an entered multi-digit access code against the stored key, one 4-bit digit per clock.
- Tracks failed attempts and enforces a timed lockout.
- Sits between the keypad capture logic and the access/alarm logic of the security system.
- Always compares all digits, so the comparison time does not reveal which digit failed.

Parameters:
- DIGITS, 4, number of 4-bit digits per code (1..8).
- MAX_TRIES, 3, consecutive failed attempts allowed before lockout (1..15).
- LOCK_CYCLES, 16, length of the lockout in clock cycles (1..65535).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a comparison; sampled only in IDLE.
- code_in  input  4*DIGITS  entered code; digit 0 is in bits [3:0].
- key_in  input  4*DIGITS  stored key, same digit layout as code_in.
- sub_a  output  4  subtractor operand A (current code digit), registered.
- sub_b  output  4  subtractor operand B (current key digit), registered.
- sub_s  input  4  subtractor difference, combinational from sub_a/sub_b.
- sub_cout  input  1  subtractor carry out.
- busy  output  1  high in COMPARE and VERDICT.
- done  output  1  one-cycle pulse in VERDICT.
- match  output  1  result of the last completed comparison; held until the next VERDICT.
- locked  output  1  high during lockout.
- tries_left  output  4  remaining attempts before lockout.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-high.
  - While rst is high: state = IDLE; sub_a = 0; sub_b = 0; busy = 0; done = 0; match = 0; locked = 0; tries_left = MAX_TRIES; digit index = 0; lock counter = 0.
  - Reset mid-comparison or mid-lockout abandons the operation and clears the lockout.
- State machine: IDLE, COMPARE, VERDICT, LOCK.
- IDLE:
  - On an edge with start = 1: capture code_in and key_in into shadow registers, set idx = 0 and mismatch = 0, load sub_a/sub_b with digit 0, go to COMPARE.
  - start = 0: stay in IDLE.
- COMPARE, one cycle per digit:
  - Digit equal iff sub_s == 0 and sub_cout == 1; otherwise set mismatch = 1 (sticky).
  - If idx == DIGITS−1: go to VERDICT.
  - Else: increment idx and load sub_a/sub_b with digit idx+1 from the shadow registers.
  - No early exit on mismatch.
- VERDICT, one cycle:
  - done = 1 and match <= !mismatch.
  - On match: tries_left <= MAX_TRIES, go to IDLE.
  - On mismatch: tries_left <= tries_left − 1. If that reaches 0, go to LOCK and load the lock counter with LOCK_CYCLES; otherwise go to IDLE.
- LOCK:
  - locked = 1; lock counter decrements every cycle.
  - When the counter reaches 1 and decrements: tries_left <= MAX_TRIES, locked <= 0, go to IDLE.
  - Total time in LOCK is exactly LOCK_CYCLES cycles.
- Latency:
  - start sampled at edge 0; COMPARE occupies cycles 1..DIGITS; done is high in cycle DIGITS+1.
  - Next start can be accepted at edge DIGITS+2.
- Ignored inputs:
  - start is ignored in COMPARE, VERDICT and LOCK; no queuing.
  - Changes to code_in/key_in after the capture edge do not affect the current comparison.
- Operand hold: sub_a/sub_b hold their last value outside COMPARE.
- done, busy and locked are never high together with state IDLE.

Test Plan:
- Correct code: code = key = 0x1234, DIGITS = 4, start pulse → done in cycle 5 after start, match = 1, tries_left = 3, busy high for cycles 1..5.
- Constant-time mismatch: code 0x1235 vs key 0x1234 (digit 0 differs), then code 0x9234 (digit 3 differs) → done in cycle 5 both times, match = 0, tries_left 3→2→1.
- Lockout: three consecutive mismatches → after the third VERDICT, locked = 1 for exactly 16 cycles and start pulses are ignored. Then locked = 0, tries_left = 3, and a correct code gives match = 1.
- Recovery: mismatch (tries_left = 2), then correct code → match = 1, tries_left = 3.
- Input capture and busy start: change code_in from 0x1234 to 0x0000 the cycle after start with key 0x1234 → match = 1. A second start pulse during COMPARE creates no extra done.
- Async reset: assert rst mid-COMPARE and again mid-LOCK → outputs go to reset values immediately, no done pulse, tries_left = 3, locked = 0.

Source files
------------

// File: rtl/code_compare_sequencer_if.sv
// ----------------------------------------------------------------------------
// code_compare_sequencer_if
// Bundles the keypad-side request/result signals and the shared subtractor
// operand/result signals of the code comparison sequencer.
//   start      : comparison request (keypad side -> sequencer)
//   code_in    : entered code, digit 0 in bits [3:0]
//   key_in     : stored key, same layout as code_in
//   sub_a/b    : subtractor operands (sequencer -> subtractor)
//   sub_s      : subtractor difference (subtractor -> sequencer)
//   sub_cout   : subtractor carry out (subtractor -> sequencer)
//   busy/done  : sequencer status, done is a one-cycle verdict pulse
//   match      : result of the last completed comparison
//   locked     : lockout active
//   tries_left : remaining attempts before lockout
// Modports: slave = the sequencer, master = its environment.
// ----------------------------------------------------------------------------
interface code_compare_sequencer_if #(
  parameter int DIGITS = 4
) ();
  logic                  start;
  logic [4*DIGITS-1:0]   code_in;
  logic [4*DIGITS-1:0]   key_in;
  logic [3:0]            sub_a;
  logic [3:0]            sub_b;
  logic [3:0]            sub_s;
  logic                  sub_cout;
  logic                  busy;
  logic                  done;
  logic                  match;
  logic                  locked;
  logic [3:0]            tries_left;

  modport slave (
    input  start, code_in, key_in, sub_s, sub_cout,
    output sub_a, sub_b, busy, done, match, locked, tries_left
  );

  modport master (
    output start, code_in, key_in, sub_s, sub_cout,
    input  sub_a, sub_b, busy, done, match, locked, tries_left
  );
endinterface

// File: rtl/code_compare_sequencer.sv
// ----------------------------------------------------------------------------
// code_compare_sequencer
// Compares an entered DIGITS-digit access code against the stored key one
// 4-bit digit per clock through an external shared subtractor (A + ~B + 1).
// All digits are always compared so the comparison time is independent of
// which digit differs. Counts consecutive failures and enforces a lockout
// of LOCK_CYCLES clocks after MAX_TRIES failures.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : code_compare_sequencer_if.slave (request, operands, status)
// ----------------------------------------------------------------------------
module code_compare_sequencer #(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  code_compare_sequencer_if.slave       bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_VERDICT = 2'd2,
    S_LOCK    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [W-1:0]       r_code;
  logic [W-1:0]       r_key;
  logic [IDX_W-1:0]   r_idx;
  logic               r_mismatch;
  logic [15:0]        r_lock_cnt;
  logic [3:0]         r_tries;
  logic [3:0]         r_sub_a;
  logic [3:0]         r_sub_b;
  logic               r_busy;
  logic               r_done;
  logic               r_match;
  logic               r_locked;

  logic               w_digit_eq;
  logic               w_last;
  logic [IDX_W-1:0]   w_idx_inc;
  logic [3:0]         w_tries_dec;

  // Selects digit i (4 bits) out of a packed code/key vector.
  function automatic logic [3:0] digit_at(input logic [W-1:0] v,
                                          input logic [IDX_W-1:0] i);
    digit_at = v[{i, 2'b00} +: 4];
  endfunction

  // A - B is zero with carry out set only when the two digits are equal.
  assign w_digit_eq  = (bus.sub_s == 4'd0) && (bus.sub_cout == 1'b1);
  assign w_last      = (r_idx == IDX_W'(DIGITS - 1));
  assign w_idx_inc   = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
  assign w_tries_dec = r_tries - 4'd1;

  assign bus.sub_a      = r_sub_a;
  assign bus.sub_b      = r_sub_b;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.match      = r_match;
  assign bus.locked     = r_locked;
  assign bus.tries_left = r_tries;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = S_COMPARE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_COMPARE: begin
        if (w_last) begin
          w_next_state = S_VERDICT;
        end else begin
          w_next_state = S_COMPARE;
        end
      end
      S_VERDICT: begin
        if (r_mismatch && (w_tries_dec == 4'd0)) begin
          w_next_state = S_LOCK;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOCK: begin
        if (r_lock_cnt <= 16'd1) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_LOCK;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Status outputs, registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_busy   <= (w_next_state == S_COMPARE) || (w_next_state == S_VERDICT);
      r_done   <= (w_next_state == S_VERDICT);
      r_locked <= (w_next_state == S_LOCK);
    end
  end

  // Datapath: shadow capture, digit walk, verdict, try counter, lock timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code     <= {W{1'b0}};
      r_key      <= {W{1'b0}};
      r_idx      <= {IDX_W{1'b0}};
      r_mismatch <= 1'b0;
      r_lock_cnt <= 16'd0;
      r_tries    <= 4'(MAX_TRIES);
      r_sub_a    <= 4'd0;
      r_sub_b    <= 4'd0;
      r_match    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_code     <= bus.code_in;
            r_key      <= bus.key_in;
            r_idx      <= {IDX_W{1'b0}};
            r_mismatch <= 1'b0;
            r_sub_a    <= bus.code_in[3:0];
            r_sub_b    <= bus.key_in[3:0];
          end
        end
        S_COMPARE: begin
          // Mismatch is sticky; the walk never stops early.
          if (!w_digit_eq) begin
            r_mismatch <= 1'b1;
          end
          if (!w_last) begin
            r_idx   <= w_idx_inc;
            r_sub_a <= digit_at(r_code, w_idx_inc);
            r_sub_b <= digit_at(r_key, w_idx_inc);
          end
        end
        S_VERDICT: begin
          r_match <= !r_mismatch;
          if (r_mismatch) begin
            r_tries <= w_tries_dec;
            if (w_tries_dec == 4'd0) begin
              r_lock_cnt <= 16'(LOCK_CYCLES);
            end
          end else begin
            r_tries <= 4'(MAX_TRIES);
          end
        end
        S_LOCK: begin
          r_lock_cnt <= r_lock_cnt - 16'd1;
          if (r_lock_cnt <= 16'd1) begin
            r_tries <= 4'(MAX_TRIES);
          end
        end
        default: begin
          r_mismatch <= 1'b1;
        end
      endcase
    end
  end

endmodule
